// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencing controller.
package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        PULSE,
        SETTLE,
        DONE
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Requester-side command handshake for the SR latch controller.
interface sr_latch_ctrl_if #(
    parameter int unsigned IDX_W = 3
);
    logic             a_req;
    logic             a_op;
    logic [IDX_W-1:0] a_idx;
    logic             a_ack;
    logic             b_req;
    logic             b_op;
    logic [IDX_W-1:0] b_idx;
    logic             b_ack;
    logic             err;

    modport master (
        output a_req, a_op, a_idx, b_req, b_op, b_idx,
        input  a_ack, b_ack, err
    );

    modport slave (
        input  a_req, a_op, a_idx, b_req, b_op, b_idx,
        output a_ack, b_ack, err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the last_grant register lives in the caller.
module rr_arb2
    import sr_ctrl_pkg::*;
(
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       last_grant,
    output logic [1:0] grant_c,
    output logic       next_grant_c
);

    // Single requester always wins; on contention the one not served last wins.
    always_comb begin
        grant_c      = 2'b00;
        next_grant_c = last_grant;
        if (enable) begin
            case (req)
                2'b01: begin
                    grant_c      = 2'b01;
                    next_grant_c = REQ_A;
                end
                2'b10: begin
                    grant_c      = 2'b10;
                    next_grant_c = REQ_B;
                end
                2'b11: begin
                    if (last_grant == REQ_B) begin
                        grant_c      = 2'b01;
                        next_grant_c = REQ_A;
                    end else begin
                        grant_c      = 2'b10;
                        next_grant_c = REQ_B;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequences set/reset pulses onto an external SR latch bank for two requesters.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int unsigned N_BITS     = 6,
    parameter int unsigned IDX_W      = $clog2(N_BITS),
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sr_latch_ctrl_if.slave    bus,
    output logic [N_BITS-1:0] s,
    output logic [N_BITS-1:0] r,
    output logic [N_BITS-1:0] q_shadow,
    output logic              busy
);

    localparam int unsigned       CNT_W     = $clog2(max2(PULSE_CYC, SETTLE_CYC) + 1);
    localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'((SETTLE_CYC > 0) ? (SETTLE_CYC - 1) : 0);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               in_init;
    logic               last_grant;
    logic               cap_op;
    logic               cap_id;
    logic               cap_err;
    logic [IDX_W-1:0]   cap_idx;

    logic [1:0]         grant_c;
    logic               next_grant_c;
    logic               arb_en_c;
    logic               sel_op_c;
    logic               sel_oor_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic [N_BITS-1:0]  mask_c;

    assign arb_en_c  = (state == IDLE);
    assign sel_op_c  = grant_c[1] ? bus.b_op  : bus.a_op;
    assign sel_idx_c = grant_c[1] ? bus.b_idx : bus.a_idx;
    assign sel_oor_c = (32'(sel_idx_c) >= N_BITS);
    assign mask_c    = N_BITS'(1) << cap_idx;

    rr_arb2 u_arb (
        .req          ({bus.b_req, bus.a_req}),
        .enable       (arb_en_c),
        .last_grant   (last_grant),
        .grant_c      (grant_c),
        .next_grant_c (next_grant_c)
    );

    // Controller FSM; every output is a registered decode of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            cnt        <= PULSE_LD;
            in_init    <= 1'b1;
            last_grant <= REQ_B;
            cap_op     <= OP_RESET;
            cap_id     <= REQ_A;
            cap_err    <= 1'b0;
            cap_idx    <= '0;
            s          <= '0;
            r          <= '0;
            q_shadow   <= '0;
            busy       <= 1'b1;
            bus.a_ack  <= 1'b0;
            bus.b_ack  <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            s         <= '0;
            r         <= '0;
            bus.a_ack <= 1'b0;
            bus.b_ack <= 1'b0;
            bus.err   <= 1'b0;
            busy      <= (state != IDLE);
            case (state)
                INIT: begin
                    r <= '1;
                    if (cnt == '0) begin
                        if (SETTLE_CYC == 0) begin
                            state   <= IDLE;
                            in_init <= 1'b0;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (|grant_c) begin
                        last_grant <= next_grant_c;
                        cap_op     <= sel_op_c;
                        cap_idx    <= sel_idx_c;
                        cap_id     <= grant_c[1] ? REQ_B : REQ_A;
                        cap_err    <= sel_oor_c;
                        if (sel_oor_c) begin
                            state <= DONE;
                        end else begin
                            state <= PULSE;
                            cnt   <= PULSE_LD;
                        end
                    end
                end
                PULSE: begin
                    case (cap_op)
                        OP_SET:   s <= mask_c;
                        OP_RESET: r <= mask_c;
                        default:  ;
                    endcase
                    if (cnt == '0) begin
                        if (SETTLE_CYC == 0) begin
                            state <= DONE;
                        end else begin
                            state <= SETTLE;
                            cnt   <= SETTLE_LD;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state   <= in_init ? IDLE : DONE;
                        in_init <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (cap_id == REQ_A) begin
                        bus.a_ack <= 1'b1;
                    end else begin
                        bus.b_ack <= 1'b1;
                    end
                    bus.err <= cap_err;
                    if (!cap_err) begin
                        q_shadow <= (cap_op == OP_SET) ? (q_shadow | mask_c) : (q_shadow & ~mask_c);
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= INIT;
                    cnt   <= PULSE_LD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Scoreboard bench for sr_latch_ctrl: expected acks queued at drive time, checked on ack.
module tb_sr_latch_ctrl;
    import sr_ctrl_pkg::*;

    localparam int unsigned N_BITS = 6;
    localparam int unsigned IDX_W  = 3;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_BITS-1:0] s;
    logic [N_BITS-1:0] r;
    logic [N_BITS-1:0] q_shadow;
    logic              busy;

    sr_latch_ctrl_if #(.IDX_W(IDX_W)) bus ();

    sr_latch_ctrl #(
        .N_BITS     (N_BITS),
        .IDX_W      (IDX_W),
        .PULSE_CYC  (2),
        .SETTLE_CYC (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .s        (s),
        .r        (r),
        .q_shadow (q_shadow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_cnt);
        end
    endtask

    typedef struct {
        logic              id;
        logic              err;
        int                edge_no;
        logic [N_BITS-1:0] q;
    } exp_t;

    typedef struct {
        logic             op;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    exp_t sb[$];
    cmd_t a_cmds[$];
    cmd_t b_cmds[$];

    logic [N_BITS-1:0] model_q = '0;

    // Queue the expected completion of one command, in service order.
    function automatic void expect_cmd(input logic id, input logic op, input logic [IDX_W-1:0] idx,
                                       input int edge_no);
        exp_t e;
        e.id      = id;
        e.err     = (32'(idx) >= N_BITS);
        e.edge_no = edge_no;
        if (!e.err) model_q[idx] = op;
        e.q = model_q;
        sb.push_back(e);
    endfunction

    // Activity accumulators cleared by each test.
    logic [N_BITS-1:0] s_or = '0;
    logic [N_BITS-1:0] r_or = '0;
    int s_cycles = 0;
    int r_cycles = 0;

    task automatic clear_acc();
        s_or = '0;
        r_or = '0;
        s_cycles = 0;
        r_cycles = 0;
    endtask

    logic              q_pend = 1'b0;
    logic [N_BITS-1:0] q_exp  = '0;

    // Output monitor: disjoint s/r, ack scoreboard, shadow one cycle after ack.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q_pend = 1'b0;
        end else begin
            check_val("s_r_disjoint", 32'(s & r), 32'd0);
            check_val("err_only_with_ack", 32'(bus.err && !(bus.a_ack || bus.b_ack)), 32'd0);
            s_or = s_or | s;
            r_or = r_or | r;
            if (s != '0) s_cycles++;
            if (r != '0) r_cycles++;
            if (q_pend) begin
                check_val("q_shadow_after_ack", 32'(q_shadow), 32'(q_exp));
                q_pend = 1'b0;
            end
            if (bus.a_ack || bus.b_ack) begin
                check_val("ack_expected", 32'(sb.size() > 0), 32'd1);
                check_val("ack_single", 32'(bus.a_ack && bus.b_ack), 32'd0);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_val("ack_id", 32'(bus.b_ack), 32'(e.id));
                    check_val("ack_err", 32'(bus.err), 32'(e.err));
                    check_val("ack_edge", 32'(edge_cnt), 32'(e.edge_no));
                    q_pend = 1'b1;
                    q_exp  = e.q;
                end
            end
        end
    end

    task automatic set_req(input logic id, input logic v, input cmd_t c);
        if (id == REQ_A) begin
            bus.a_req = v;
            bus.a_op  = c.op;
            bus.a_idx = c.idx;
        end else begin
            bus.b_req = v;
            bus.b_op  = c.op;
            bus.b_idx = c.idx;
        end
    endtask

    // Requester model: holds req across its queued commands, advancing on each ack.
    task automatic serve(input logic id);
        cmd_t  c;
        int    guard;
        logic  got;
        int    left;
        string tag;
        tag  = (id == REQ_A) ? "a_ack_seen" : "b_ack_seen";
        left = (id == REQ_A) ? a_cmds.size() : b_cmds.size();
        if (left == 0) return;
        c = (id == REQ_A) ? a_cmds[0] : b_cmds[0];
        set_req(id, 1'b1, c);
        forever begin
            guard = 0;
            got   = 1'b0;
            while (!got && guard < 40) begin
                @(negedge clk);
                guard++;
                got = (id == REQ_A) ? bus.a_ack : bus.b_ack;
            end
            check_val(tag, 32'(got), 32'd1);
            if (id == REQ_A) void'(a_cmds.pop_front());
            else             void'(b_cmds.pop_front());
            left = (id == REQ_A) ? a_cmds.size() : b_cmds.size();
            if (!got || left == 0) begin
                set_req(id, 1'b0, c);
                if (id == REQ_A) a_cmds.delete();
                else             b_cmds.delete();
                return;
            end
            c = (id == REQ_A) ? a_cmds[0] : b_cmds[0];
            set_req(id, 1'b1, c);
        end
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check_val("reach_idle", 32'(busy), 32'd0);
    endtask

    // Release reset at a falling edge and follow the clear-bank sequence.
    task automatic release_and_check_init();
        logic [N_BITS-1:0] exp_r [5];
        logic              exp_b [5];
        exp_r = '{6'h00, 6'h3f, 6'h3f, 6'h00, 6'h00};
        exp_b = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        model_q = '0;
        rst_n = 1'b1;
        #1;
        check_val("rst_q_shadow", 32'(q_shadow), 32'd0);
        check_val("rst_s", 32'(s), 32'd0);
        check_val("rst_acks", 32'({bus.a_ack, bus.b_ack, bus.err}), 32'd0);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check_val($sformatf("init_r_%0d", k), 32'(r), 32'(exp_r[k]));
            check_val($sformatf("init_busy_%0d", k), 32'(busy), 32'(exp_b[k]));
        end
    endtask

    // A and B together: A wins (last grant is B), B follows five cycles after A's ack.
    task automatic contention(input logic [IDX_W-1:0] a_idx, input logic [IDX_W-1:0] b_idx);
        int   t;
        cmd_t ca;
        cmd_t cb;
        wait_idle();
        t = edge_cnt + 1;
        ca.op = OP_SET;   ca.idx = a_idx;
        cb.op = OP_RESET; cb.idx = b_idx;
        expect_cmd(REQ_A, ca.op, ca.idx, t + 4);
        expect_cmd(REQ_B, cb.op, cb.idx, t + 9);
        a_cmds.push_back(ca);
        b_cmds.push_back(cb);
        fork
            serve(REQ_A);
            serve(REQ_B);
        join
        @(negedge clk);
        check_val("cont_q_a_bit", 32'(q_shadow[a_idx]), 32'd1);
        check_val("cont_q_b_bit", 32'(q_shadow[b_idx]), 32'd0);
    endtask

    initial begin
        int   t;
        cmd_t c;
        bus.a_req = 1'b0; bus.a_op = 1'b0; bus.a_idx = '0;
        bus.b_req = 1'b0; bus.b_op = 1'b0; bus.b_idx = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        release_and_check_init();

        contention(3'd0, 3'd3);

        // Single set of bit 3.
        wait_idle();
        clear_acc();
        t = edge_cnt + 1;
        c.op = OP_SET; c.idx = 3'd3;
        expect_cmd(REQ_A, c.op, c.idx, t + 4);
        a_cmds.push_back(c);
        serve(REQ_A);
        @(negedge clk);
        check_val("set3_s_bits", 32'(s_or), 32'h08);
        check_val("set3_s_width", 32'(s_cycles), 32'd2);
        check_val("set3_r_quiet", 32'(r_cycles), 32'd0);

        // Out-of-range index: immediate ack with err, no latch activity.
        wait_idle();
        clear_acc();
        t = edge_cnt + 1;
        c.op = OP_SET; c.idx = 3'd7;
        expect_cmd(REQ_B, c.op, c.idx, t + 1);
        b_cmds.push_back(c);
        serve(REQ_B);
        @(negedge clk);
        check_val("oor_no_sr", 32'(s_or | r_or), 32'd0);

        // A holds req across three commands.
        wait_idle();
        clear_acc();
        t = edge_cnt + 1;
        c.op = OP_SET;   c.idx = 3'd1; expect_cmd(REQ_A, c.op, c.idx, t + 4);  a_cmds.push_back(c);
        c.op = OP_SET;   c.idx = 3'd4; expect_cmd(REQ_A, c.op, c.idx, t + 9);  a_cmds.push_back(c);
        c.op = OP_RESET; c.idx = 3'd1; expect_cmd(REQ_A, c.op, c.idx, t + 14); a_cmds.push_back(c);
        serve(REQ_A);
        @(negedge clk);
        check_val("b2b_s_cycles", 32'(s_cycles), 32'd4);
        check_val("b2b_r_cycles", 32'(r_cycles), 32'd2);
        check_val("b2b_bits", 32'(s_or | r_or), 32'h12);

        // Reset during the pulse of A set idx 2: command dropped, bank re-initialised.
        wait_idle();
        c.op = OP_SET; c.idx = 3'd2;
        set_req(REQ_A, 1'b1, c);
        @(negedge clk);
        set_req(REQ_A, 1'b0, c);
        @(negedge clk);
        check_val("midrst_s_pulse", 32'(s), 32'h04);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("midrst_s_clear", 32'(s), 32'd0);
        check_val("midrst_r_clear", 32'(r), 32'd0);
        check_val("midrst_ack_clear", 32'({bus.a_ack, bus.b_ack, bus.err}), 32'd0);
        check_val("midrst_q_clear", 32'(q_shadow), 32'd0);
        repeat (2) @(negedge clk);
        release_and_check_init();

        // After reset A must again win contention.
        contention(3'd5, 3'd0);

        wait_idle();
        repeat (3) @(negedge clk);
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
